mod_subtractor_pipe: RTL and testbench

Pipelined modular subtractor computing r = (a − b) mod M, with M = 2^N_BIT − K. It is the inverse-direction companion of the modular adder: the adder produces a + b mod M, and this block produces the difference in the same residue system. Operands arrive over a valid/ready stream, and results leave over a valid/ready stream after a fixed two-stage pipeline. It sits beside the modular adder in the residue-arithmetic datapath.

---
 rtl/mod_arith_pkg.sv | 23 ++
 rtl/mod_sub_core.sv | 30 +++
 rtl/mod_subtractor_pipe.sv | 87 ++++++++
 tb/tb_mod_subtractor_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mod_arith_pkg.sv
// rtl/mod_arith_pkg.sv - shared types, constants and helpers for the residue-arithmetic datapath
package mod_arith_pkg;

   localparam int N_BIT_DEF = 7;
   localparam int K_DEF     = 3;

   typedef logic [N_BIT_DEF-1:0] residue_t;

   // Stage-1 record: the low bits of a - b plus the borrow carry the full
   // N_BIT+1 difference, so the sign bit is held only once.
   typedef struct packed {
      residue_t d;
      residue_t e;
      logic     borrow;
      logic     err;
      logic     v;
   } s1_rec_t;

   function automatic int unsigned mod_m(input int unsigned n_bit, input int unsigned k);
      return (32'd1 << n_bit) - k;
   endfunction

endpackage

// File: rtl/mod_sub_core.sv
// rtl/mod_sub_core.sv - combinational difference, wrapped difference and operand range check
module mod_sub_core
   import mod_arith_pkg::*;
#(
   parameter int N_BIT = N_BIT_DEF,
   parameter int K     = K_DEF
) (
   input  logic [N_BIT-1:0] a,
   input  logic [N_BIT-1:0] b,
   output logic [N_BIT-1:0] d,
   output logic [N_BIT-1:0] e,
   output logic             borrow,
   output logic             err
);

   localparam logic [N_BIT:0]   M_V = (N_BIT+1)'(mod_m(N_BIT, K));
   localparam logic [N_BIT-1:0] K_V = N_BIT'(K);

   logic [N_BIT:0] diff;

   // When a - b borrows, adding M is the same as subtracting K modulo 2^N_BIT.
   always_comb begin
      diff   = {1'b0, a} - {1'b0, b};
      d      = diff[N_BIT-1:0];
      borrow = diff[N_BIT];
      e      = diff[N_BIT-1:0] - K_V;
      err    = ({1'b0, a} >= M_V) | ({1'b0, b} >= M_V);
   end

endmodule

// File: rtl/mod_subtractor_pipe.sv
// rtl/mod_subtractor_pipe.sv - two-stage valid/ready pipeline computing (a - b) mod (2^N_BIT - K)
module mod_subtractor_pipe
   import mod_arith_pkg::*;
#(
   parameter int N_BIT = N_BIT_DEF,
   parameter int K     = K_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_BIT-1:0] a,
   input  logic [N_BIT-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N_BIT-1:0] r,
   output logic             out_err
);

   typedef struct packed {
      logic [N_BIT-1:0] d;
      logic [N_BIT-1:0] e;
      logic             borrow;
      logic             err;
      logic             v;
   } s1_t;

   s1_t              s1_q;
   logic [N_BIT-1:0] c_d;
   logic [N_BIT-1:0] c_e;
   logic             c_borrow;
   logic             c_err;
   logic             adv2;

   mod_sub_core #(
      .N_BIT (N_BIT),
      .K     (K)
   ) u_core (
      .a      (a),
      .b      (b),
      .d      (c_d),
      .e      (c_e),
      .borrow (c_borrow),
      .err    (c_err)
   );

   // S2 can take a new entry when empty or when its result leaves this edge;
   // out_ready -> in_ready is the only combinational path through the block.
   assign adv2     = !out_valid | out_ready;
   assign in_ready = !s1_q.v | adv2;

   // Stage 1: capture the core's outputs whenever S1 is free or draining into S2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
      end else if (in_ready) begin
         s1_q.v <= in_valid;
         if (in_valid) begin
            s1_q.d      <= c_d;
            s1_q.e      <= c_e;
            s1_q.borrow <= c_borrow;
            s1_q.err    <= c_err;
         end
      end
   end

   // Stage 2: select the wrapped or plain difference; hold r/out_err while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         r         <= '0;
         out_err   <= 1'b0;
      end else if (adv2) begin
         out_valid <= s1_q.v;
         if (s1_q.v) begin
            out_err <= s1_q.err;
            if (s1_q.err)
               r <= '0;
            else if (s1_q.borrow)
               r <= s1_q.e;
            else
               r <= s1_q.d;
         end
      end
   end

endmodule

// File: tb/tb_mod_subtractor_pipe.sv
// tb/tb_mod_subtractor_pipe.sv - self-checking bench for mod_subtractor_pipe
module tb_mod_subtractor_pipe;
   import mod_arith_pkg::*;

   localparam int M = 125;

   logic     clk = 1'b0;
   logic     rst_n;
   logic     in_valid, in_ready, out_valid, out_ready, out_err;
   residue_t a, b, r;
   logic     k0_in_valid, k0_in_ready, k0_out_valid, k0_out_ready, k0_out_err;
   residue_t k0_a, k0_b, k0_r;

   always #5 clk = ~clk;

   mod_subtractor_pipe #(.N_BIT(7), .K(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .r         (r),
      .out_err   (out_err)
   );

   mod_subtractor_pipe #(.N_BIT(7), .K(0)) dut_k0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (k0_in_valid),
      .in_ready  (k0_in_ready),
      .a         (k0_a),
      .b         (k0_b),
      .out_valid (k0_out_valid),
      .out_ready (k0_out_ready),
      .r         (k0_r),
      .out_err   (k0_out_err)
   );

   typedef struct {
      int r;
      bit err;
      int t;
   } exp_t;

   typedef struct {
      int a;
      int b;
      int r;
      bit err;
   } vec_t;

   exp_t q[$];
   vec_t tv[7];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   bit   prev_stall = 0;
   int   prev_r;
   bit   prev_err;

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void ref_sub(input int x, input int y, output int rr, output bit ee);
      if (x >= M || y >= M) begin
         rr = 0;
         ee = 1'b1;
      end else begin
         rr = (x - y + M) % M;
         ee = 1'b0;
      end
   endfunction

   task automatic step(input bit iv, input int ia, input int ib, input bit ordy,
                       input int er, input bit ee, output bit acc);
      in_valid  = iv;
      a         = residue_t'(ia);
      b         = residue_t'(ib);
      out_ready = ordy;
      @(negedge clk);
      chk("in_ready", in_ready, int'((q.size() < 2) || ordy));
      chk("out_valid", out_valid, int'(q.size() > 0 && cyc >= q[0].t + 2));
      if (prev_stall && out_valid) begin
         chk("stall_r", r, prev_r);
         chk("stall_err", out_err, int'(prev_err));
      end
      prev_stall = out_valid && !ordy;
      prev_r     = int'(r);
      prev_err   = out_err;
      if (out_valid && ordy) begin
         if (q.size() == 0) begin
            chk("spurious_out", out_valid, 0);
         end else begin
            chk("r", r, q[0].r);
            chk("out_err", out_err, int'(q[0].err));
            void'(q.pop_front());
         end
      end
      acc = iv && in_ready;
      if (acc) q.push_back('{r: er, err: ee, t: cyc});
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic drain();
      bit acc;
      for (int i = 0; i < 20 && q.size() > 0; i++) step(0, 0, 0, 1, 0, 0, acc);
      chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      bit acc;
      int pa, pb, pr, sent;
      bit pe;

      tv[0] = '{a: 5,   b: 3,   r: 2,   err: 0};
      tv[1] = '{a: 0,   b: 1,   r: 124, err: 0};
      tv[2] = '{a: 0,   b: 124, r: 1,   err: 0};
      tv[3] = '{a: 124, b: 0,   r: 124, err: 0};
      tv[4] = '{a: 77,  b: 77,  r: 0,   err: 0};
      tv[5] = '{a: 126, b: 4,   r: 0,   err: 1};
      tv[6] = '{a: 10,  b: 20,  r: 115, err: 0};

      rst_n = 1'b0; in_valid = 0; a = '0; b = '0; out_ready = 0;
      k0_in_valid = 0; k0_a = '0; k0_b = '0; k0_out_ready = 1;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_r", r, 0);
      chk("rst_out_err", out_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors, one at a time so each latency is seen in isolation.
      foreach (tv[i]) begin
         step(1, tv[i].a, tv[i].b, 1, tv[i].r, tv[i].err, acc);
         chk("vec_accept", acc, 1);
         drain();
      end

      // Fill both stages with out_ready low, a third pair must be refused,
      // then out_ready rises: output, advance and input on the same edge.
      ref_sub(40, 50, pr, pe); step(1, 40, 50, 0, pr, pe, acc);
      ref_sub(60, 10, pr, pe); step(1, 60, 10, 0, pr, pe, acc);
      ref_sub(3, 99, pr, pe);  step(1, 3, 99, 0, pr, pe, acc);
      chk("full_refuse", acc, 0);
      step(1, 3, 99, 0, pr, pe, acc);
      step(1, 3, 99, 1, pr, pe, acc);
      chk("full_accept_on_release", acc, 1);
      drain();

      // Random back-pressure: 10 legal pairs, held until accepted.
      sent = 0;
      pa = $urandom_range(0, M-1); pb = $urandom_range(0, M-1);
      for (int i = 0; i < 300 && sent < 10; i++) begin
         ref_sub(pa, pb, pr, pe);
         step(1, pa, pb, 1'($urandom_range(0, 1)), pr, pe, acc);
         if (acc) begin
            sent++;
            pa = $urandom_range(0, M-1); pb = $urandom_range(0, M-1);
         end
      end
      chk("bp_sent", sent, 10);
      drain();

      // Reset with two pairs in flight.
      ref_sub(11, 22, pr, pe); step(1, 11, 22, 0, pr, pe, acc);
      ref_sub(33, 2, pr, pe);  step(1, 33, 2, 0, pr, pe, acc);
      in_valid = 0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_r", r, 0);
      chk("midrst_out_err", out_err, 0);
      chk("midrst_in_ready", in_ready, 1);
      q.delete();
      prev_stall = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, acc);

      // Full throughput: 64 back-to-back pairs, no bubbles allowed.
      for (int i = 0; i < 64; i++) begin
         pa = $urandom_range(0, M-1); pb = $urandom_range(0, M-1);
         ref_sub(pa, pb, pr, pe);
         step(1, pa, pb, 1, pr, pe, acc);
         chk("tp_accept", acc, 1);
      end
      drain();

      // K = 0 build: plain 2^7 wrap.
      in_valid = 0;
      k0_in_valid = 1; k0_a = 7'd0; k0_b = 7'd1;
      @(negedge clk);
      chk("k0_in_ready", k0_in_ready, 1);
      @(posedge clk); #1;
      k0_a = 7'd3; k0_b = 7'd1;
      @(negedge clk);
      @(posedge clk); #1;
      k0_in_valid = 0;
      @(negedge clk);
      chk("k0_valid0", k0_out_valid, 1);
      chk("k0_r0", k0_r, 127);
      chk("k0_err0", k0_out_err, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("k0_valid1", k0_out_valid, 1);
      chk("k0_r1", k0_r, 2);
      @(posedge clk); #1;
      @(negedge clk);
      chk("k0_idle", k0_out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
